demux_1x2_dispatcher: RTL and testbench
=======================================

// Module: demux_1x2_dispatcher
// PURPOSE
//  Sequences a 1x2 demux datapath. Accepts a stream of input beats over a valid/ready
//  handshake and steers each beat to one of two output channels, each with its own handshake.
//  Steering policy: work-conserving round-robin, or a directed select.
//  Each channel has a one-entry holding slot and a beat counter.
//  Sits between a single producer and two consumers that share it.
// PARAMETERS
//  WIDTH  8  data width of a beat
//  CNT_W  8  width of each per-channel accepted-beat counter
// PORTS
//  clk        in   1      single clock; all state updates on posedge clk
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      producer has a beat on in_data
//  in_ready   out  1      dispatcher accepts the beat this cycle
//  in_data    in   WIDTH  input beat
//  mode       in   1      0 = round-robin, 1 = directed
//  dir_sel    in   1      target channel when mode=1
//  out_valid  out  2      out_valid[c]: channel c slot holds a beat
//  out_ready  in   2      out_ready[c]: consumer c takes the beat
//  out_data0  out  WIDTH  channel 0 beat
//  out_data1  out  WIDTH  channel 1 beat
//  cnt0       out  CNT_W  beats accepted into channel 0
//  cnt1       out  CNT_W  beats accepted into channel 1
// BEHAVIOUR
//  - Reset (rst=1 at posedge): clears out_valid, out_data0/1, cnt0/1 and ptr.
//    ptr is the round-robin pointer; reset value 0.
//    in_ready is forced 0 while rst=1.
//  - free[c] = !out_valid[c] | out_ready[c]. A slot that drains this cycle may refill.
//  - Target channel tgt:
//    - mode=1: tgt = dir_sel. No fallback to the other channel.
//    - mode=0: tgt = ptr if free[ptr], else ~ptr if free[~ptr], else ptr.
//  - in_ready = !rst & free[tgt] (combinational). Accept = in_valid & in_ready.
//  - On accept to channel c:
//    - slot c <= in_data; out_valid[c] <= 1; cnt_c <= cnt_c + 1.
//    - cnt_c wraps modulo 2^CNT_W.
//  - Round-robin pointer:
//    - On accept in mode=0: ptr <= ~tgt.
//    - mode=1 never changes ptr.
//  - Drain without refill: out_valid[c] <= 0 and out_data holds its last value.
//  - Drain and refill in the same cycle: new data loads; out_valid[c] stays 1.
//    Gives back-to-back throughput of 1 beat/cycle per channel.
//  - Stall: while out_valid[c] & !out_ready[c], out_data_c and out_valid[c] are stable.
//  - Latency: a beat accepted at edge N is visible on out_* after edge N (1 cycle).
//    There is no combinational in->out path.
//  - Both slots full and no drain: in_ready=0; in_data is ignored.
//  - mode/dir_sel changes take effect for the tgt evaluation in that same cycle.
//    Beats already held are unaffected.
//  - Reset mid-operation discards held beats; counters restart at 0.
//  - in_data is never dropped or duplicated. Ordering is preserved within each channel.
// STRUCTURE
//  - Package demux_dispatch_pkg:
//    - localparams CH0=1'b0, CH1=1'b1.
//    - typedef enum logic {MODE_RR=1'b0, MODE_DIR=1'b1} mode_t.
//  - Sub-module dispatch_slot: one-entry holding register plus counter, instantiated twice.
//    Ports: clk, rst, load, data_in, ready_in, valid, data, cnt.
//  - Top level holds only the tgt/in_ready logic and the ptr flop.
// TESTING
//  1. Reset: rst=1 for 2 cycles with in_valid=1.
//     -> in_ready=0; out_valid=2'b00; cnt0=cnt1=0; outputs 0 after release.
//  2. RR streaming: mode=0, out_ready=2'b11, beats 0x11,0x22,0x33,0x44.
//     -> ch0 gets 0x11,0x33; ch1 gets 0x22,0x44; cnt0=cnt1=2; in_ready stays 1.
//  3. Work-conserving skip: mode=0, out_ready=2'b10, ch0 already full.
//     Beats 0xA0,0xA1 -> both go to ch1; ch0 beat held stable; cnt1=+2.
//  4. Directed backpressure: mode=1, dir_sel=1, out_ready[1]=0.
//     Send 0x5A then 0x5B -> 0x5A held; in_ready=0 with 0x5B pending.
//     Raise out_ready[1] -> 0x5B loads the same cycle 0x5A drains.
//  5. Counter wrap: CNT_W=8, 256 beats directed to ch0 -> cnt0 returns to 0x00; cnt1 unchanged.
//  6. Mid-stream reset: rst=1 with both slots full.
//     -> next cycle out_valid=2'b00, cnts=0, ptr=0; first beat after release goes to ch0.

Source files
------------

// File: rtl/demux_dispatch_pkg.sv
// Shared types for the 1x2 demux dispatcher.
// Channel ids, steering modes and the slot-free test.
package demux_dispatch_pkg;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  typedef enum logic {
    MODE_RR  = 1'b0,
    MODE_DIR = 1'b1
  } mode_t;

  // A slot draining this cycle counts as free so it can refill.
  function automatic logic slot_free(
    input logic valid,
    input logic ready
  );
    return !valid | ready;
  endfunction

endpackage

// File: rtl/demux_1x2_dispatcher_if.sv
// Producer and consumer handshakes of the 1x2 dispatcher.
// master = producer/consumer side, slave = dispatcher side.
interface demux_1x2_dispatcher_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             mode;
  logic             dir_sel;
  logic [1:0]       out_valid;
  logic [1:0]       out_ready;
  logic [WIDTH-1:0] out_data0;
  logic [WIDTH-1:0] out_data1;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  modport master (
    output in_valid,
    output in_data,
    output mode,
    output dir_sel,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data0,
    input  out_data1,
    input  cnt0,
    input  cnt1
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  mode,
    input  dir_sel,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data0,
    output out_data1,
    output cnt0,
    output cnt1
  );

endinterface

// File: rtl/dispatch_slot.sv
// One-entry holding register with an accepted-beat counter.
// Load wins over drain, giving 1 beat/cycle throughput.
module dispatch_slot #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ready_in,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] cnt
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_data  <= data_in;
      r_cnt   <= r_cnt + CNT_W'(1);
    end else if (ready_in) begin
      r_valid <= 1'b0;
    end
  end

  assign valid = r_valid;
  assign data  = r_data;
  assign cnt   = r_cnt;

endmodule

// File: rtl/demux_1x2_dispatcher.sv
// Steers an input stream to two channels, round-robin or directed.
// Only target selection and the round-robin pointer live here.
module demux_1x2_dispatcher
  import demux_dispatch_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input logic                   clk,
  input logic                   rst,
  demux_1x2_dispatcher_if.slave bus
);

  mode_t      w_mode;
  logic [1:0] w_valid;
  logic [1:0] w_free;
  logic [1:0] w_load;
  logic       w_alt;
  logic       w_dir;
  logic       w_rr_keep;
  logic       w_rr_swap;
  logic       w_tgt;
  logic       w_in_ready;
  logic       w_accept;
  logic       r_ptr;

  assign w_mode = mode_t'(bus.mode);
  assign w_alt  = ~r_ptr;

  assign w_free[CH0] = slot_free(w_valid[CH0], bus.out_ready[CH0]);
  assign w_free[CH1] = slot_free(w_valid[CH1], bus.out_ready[CH1]);

  assign w_dir     = (w_mode == MODE_DIR);
  assign w_rr_keep = !w_dir & w_free[r_ptr];
  assign w_rr_swap = !w_dir & !w_free[r_ptr] & w_free[w_alt];

  // Work-conserving: skip a blocked pointer channel, never in directed mode.
  always_comb begin
    w_tgt = r_ptr;
    unique case (1'b1)
      w_dir:     w_tgt = bus.dir_sel;
      w_rr_keep: w_tgt = r_ptr;
      w_rr_swap: w_tgt = w_alt;
      default:   w_tgt = r_ptr;
    endcase
  end

  assign w_in_ready = !rst & w_free[w_tgt];
  assign w_accept   = bus.in_valid & w_in_ready;

  assign w_load[CH0] = w_accept & (w_tgt == CH0);
  assign w_load[CH1] = w_accept & (w_tgt == CH1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= CH0;
    end else if (w_accept && w_mode == MODE_RR) begin
      r_ptr <= ~w_tgt;
    end
  end

  dispatch_slot #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_slot0 (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load[CH0]),
    .data_in  (bus.in_data),
    .ready_in (bus.out_ready[CH0]),
    .valid    (w_valid[CH0]),
    .data     (bus.out_data0),
    .cnt      (bus.cnt0)
  );

  dispatch_slot #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_slot1 (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load[CH1]),
    .data_in  (bus.in_data),
    .ready_in (bus.out_ready[CH1]),
    .valid    (w_valid[CH1]),
    .data     (bus.out_data1),
    .cnt      (bus.cnt1)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_valid;

endmodule

// File: tb/tb_demux_1x2_dispatcher.sv
// Bench for demux_1x2_dispatcher: directed table, wrap, random vs model.
// Model keeps per-channel queues of held beats and plain counters.
module tb_demux_1x2_dispatcher;

  logic clk;
  logic rst;

  demux_1x2_dispatcher_if #(.WIDTH(8), .CNT_W(8)) bus ();

  demux_1x2_dispatcher #(
    .WIDTH (8),
    .CNT_W (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] hold [2][$];
  logic [7:0] last [2];
  int         cnt  [2];
  int         ptr;

  typedef struct {
    logic       r;
    logic       iv;
    logic [7:0] d;
    logic       md;
    logic       ds;
    logic [1:0] ordy;
    logic       e_ir;
    logic [1:0] e_ov;
    logic [7:0] e_d0;
    logic [7:0] e_d1;
    logic [7:0] e_c0;
    logic [7:0] e_c1;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic m_free(input int c, input logic [1:0] ordy);
    return hold[c].size() == 0 || ordy[c];
  endfunction

  function automatic int m_tgt(input logic md, input logic ds,
                               input logic [1:0] ordy);
    if (md) return int'(ds);
    if (m_free(ptr, ordy)) return ptr;
    if (m_free(1 - ptr, ordy)) return 1 - ptr;
    return ptr;
  endfunction

  task automatic m_reset();
    for (int c = 0; c < 2; c++) begin
      hold[c].delete();
      last[c] = 8'h00;
      cnt[c]  = 0;
    end
    ptr = 0;
  endtask

  task automatic step(input logic r, input logic iv, input logic [7:0] d,
                      input logic md, input logic ds,
                      input logic [1:0] ordy, output logic got_ir);
    int   t;
    logic eir;
    logic acc;
    rst           = r;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.mode      = md;
    bus.dir_sel   = ds;
    bus.out_ready = ordy;
    #1;
    t   = m_tgt(md, ds, ordy);
    eir = !r && m_free(t, ordy);
    acc = iv && eir;
    got_ir = bus.in_ready;
    chk("in_ready", 32'(bus.in_ready), 32'(eir));
    @(posedge clk);
    if (r) begin
      m_reset();
    end else begin
      for (int c = 0; c < 2; c++)
        if (hold[c].size() != 0 && ordy[c]) void'(hold[c].pop_front());
      if (acc) begin
        hold[t].push_back(d);
        last[t] = d;
        cnt[t]  = (cnt[t] + 1) % 256;
        if (!md) ptr = 1 - t;
      end
    end
    #1;
    chk("out_valid", 32'(bus.out_valid),
        32'({hold[1].size() != 0, hold[0].size() != 0}));
    chk("out_data0", 32'(bus.out_data0), 32'(last[0]));
    chk("out_data1", 32'(bus.out_data1), 32'(last[1]));
    chk("cnt0", 32'(bus.cnt0), 32'(cnt[0]));
    chk("cnt1", 32'(bus.cnt1), 32'(cnt[1]));
  endtask

  initial begin
    logic ir;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.mode      = 1'b0;
    bus.dir_sel   = 1'b0;
    bus.out_ready = 2'b00;
    m_reset();

    tbl[0]  = '{1,1,8'hFF,0,0,2'b00, 0,2'b00,8'h00,8'h00,8'd0,8'd0};
    tbl[1]  = '{1,1,8'hFF,0,0,2'b00, 0,2'b00,8'h00,8'h00,8'd0,8'd0};
    tbl[2]  = '{0,1,8'h11,0,0,2'b11, 1,2'b01,8'h11,8'h00,8'd1,8'd0};
    tbl[3]  = '{0,1,8'h22,0,0,2'b11, 1,2'b10,8'h11,8'h22,8'd1,8'd1};
    tbl[4]  = '{0,1,8'h33,0,0,2'b11, 1,2'b01,8'h33,8'h22,8'd2,8'd1};
    tbl[5]  = '{0,1,8'h44,0,0,2'b11, 1,2'b10,8'h33,8'h44,8'd2,8'd2};
    tbl[6]  = '{0,1,8'h55,0,0,2'b11, 1,2'b01,8'h55,8'h44,8'd3,8'd2};
    tbl[7]  = '{0,1,8'hA0,0,0,2'b10, 1,2'b11,8'h55,8'hA0,8'd3,8'd3};
    tbl[8]  = '{0,1,8'hA1,0,0,2'b10, 1,2'b11,8'h55,8'hA1,8'd3,8'd4};
    tbl[9]  = '{0,0,8'h00,1,1,2'b11, 1,2'b00,8'h55,8'hA1,8'd3,8'd4};
    tbl[10] = '{0,1,8'h5A,1,1,2'b00, 1,2'b10,8'h55,8'h5A,8'd3,8'd5};
    tbl[11] = '{0,1,8'h5B,1,1,2'b00, 0,2'b10,8'h55,8'h5A,8'd3,8'd5};
    tbl[12] = '{0,1,8'h5B,1,1,2'b10, 1,2'b10,8'h55,8'h5B,8'd3,8'd6};
    tbl[13] = '{0,0,8'h00,1,1,2'b11, 1,2'b00,8'h55,8'h5B,8'd3,8'd6};
    tbl[14] = '{0,1,8'h66,0,0,2'b11, 1,2'b01,8'h66,8'h5B,8'd4,8'd6};
    tbl[15] = '{0,1,8'h77,0,0,2'b00, 1,2'b11,8'h66,8'h77,8'd4,8'd7};
    tbl[16] = '{0,1,8'h88,0,0,2'b00, 0,2'b11,8'h66,8'h77,8'd4,8'd7};
    tbl[17] = '{1,1,8'h99,0,0,2'b00, 0,2'b00,8'h00,8'h00,8'd0,8'd0};
    tbl[18] = '{0,1,8'hAB,0,0,2'b00, 1,2'b01,8'hAB,8'h00,8'd1,8'd0};
    tbl[19] = '{0,0,8'h00,0,0,2'b11, 1,2'b00,8'hAB,8'h00,8'd1,8'd0};

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].r, tbl[i].iv, tbl[i].d, tbl[i].md, tbl[i].ds,
           tbl[i].ordy, ir);
      chk($sformatf("t%0d.in_ready", i), 32'(ir), 32'(tbl[i].e_ir));
      chk($sformatf("t%0d.out_valid", i), 32'(bus.out_valid),
          32'(tbl[i].e_ov));
      chk($sformatf("t%0d.out_data0", i), 32'(bus.out_data0),
          32'(tbl[i].e_d0));
      chk($sformatf("t%0d.out_data1", i), 32'(bus.out_data1),
          32'(tbl[i].e_d1));
      chk($sformatf("t%0d.cnt0", i), 32'(bus.cnt0), 32'(tbl[i].e_c0));
      chk($sformatf("t%0d.cnt1", i), 32'(bus.cnt1), 32'(tbl[i].e_c1));
    end

    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, ir);
    for (int i = 0; i < 256; i++)
      step(1'b0, 1'b1, 8'($urandom), 1'b1, 1'b0, 2'b11, ir);
    chk("wrap.cnt0", 32'(bus.cnt0), 32'h0);
    chk("wrap.cnt1", 32'(bus.cnt1), 32'h0);
    chk("wrap.out_valid", 32'(bus.out_valid), 32'h1);

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 63) == 0, 1'($urandom), 8'($urandom),
           1'($urandom), 1'($urandom), 2'($urandom), ir);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
